binary_round_ctrl: RTL and testbench
====================================

BINARY_ROUND_CTRL -- requirements
Module: binary_round_ctrl

Interface
REQ-001 Parameter ROUND_TICKS, default 10: CEN ticks allowed per round (range 1..255).
REQ-002 Parameter START_LIVES, default 3: lives at game start (range 1..3).
REQ-003 Parameter SCORE_MAX, default 99: score saturation value.
REQ-004 Clk  in  1  sole clock; all logic on posedge Clk.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 CEN  in  1  clock-enable tick; Start, Select, Quit and timer act only on CEN=1 cycles.
REQ-007 Start  in  1  begin new game.
REQ-008 Select  in  1  submit userNumber as the answer.
REQ-009 Quit  in  1  abort the current game.
REQ-010 userNumber  in  8  player's binary answer.
REQ-011 gen_req  out  1  request for a new random number.
REQ-012 gen_ack  in  1  generator response; gen_value valid this cycle; not CEN-gated.
REQ-013 gen_value  in  8  random number from the generator.
REQ-014 targetNumber  out  8  number shown to the player.
REQ-015 timeLeft  out  8  remaining CEN ticks in the current round.
REQ-016 score  out  7  correct answers in the current game.
REQ-017 highScore  out  7  best score since reset.
REQ-018 lives  out  2  remaining lives.
REQ-019 q_Idle, q_Request, q_Round, q_Over  out  1 each  one-hot state flags.

Function
REQ-020 FSM states: IDLE, REQUEST, ROUND, OVER; exactly one q_ flag is high at any time.
REQ-021 gen_req is a Moore output equal to (state==REQUEST); it falls the cycle after gen_ack is seen.
REQ-022 IDLE: CEN&Start -> REQUEST, with score<=0 and lives<=START_LIVES.
REQ-023 REQUEST: gen_ack -> ROUND, with targetNumber<=gen_value and timeLeft<=ROUND_TICKS; gen_ack in any other state is ignored.
REQ-024 REQUEST: CEN&Quit -> OVER; Quit takes priority over a same-cycle gen_ack.
REQ-025 ROUND priority on CEN cycles: Quit > Select > timer.
REQ-026 ROUND, CEN&Quit: -> OVER; score and lives unchanged.
REQ-027 ROUND, CEN&Select with userNumber==targetNumber: score<=min(score+1,SCORE_MAX) -> REQUEST.
REQ-028 ROUND, CEN&Select with a mismatch: lives<=lives-1; -> OVER if the new lives==0, else -> REQUEST.
REQ-029 ROUND, CEN with no Quit/Select: if timeLeft==1, treat as a mismatch (REQ-028) with timeLeft<=0; else timeLeft<=timeLeft-1.
REQ-030 Every transition into OVER sets highScore<=score if score>highScore, in the same cycle, using the post-update score.
REQ-031 OVER: CEN&Start -> REQUEST (same init as REQ-022); otherwise CEN&Select -> IDLE; all outputs hold otherwise.
REQ-032 Non-CEN cycles change nothing except REQUEST handling of gen_ack.
REQ-033 An illegal state encoding recovers to IDLE on the next cycle.

Reset
REQ-034 Reset=1 at posedge: state IDLE; gen_req 0; targetNumber, timeLeft, score, highScore, lives all 0.
REQ-035 Reset overrides all inputs, including mid-round and mid-handshake; highScore is cleared only by Reset.

Structure
REQ-036 Package binary_game_pkg holds the state encoding, SCORE_MAX default, and widths (NUM_W=8, SCORE_W=7, LIVES_W=2).
REQ-037 Sub-module round_timer (load, CEN-decrement, expire flag at 1) holds timeLeft; the FSM and score/lives logic stay in binary_round_ctrl.

Verification
REQ-038 Reset, Start+CEN, gen_ack with gen_value=0x5A, Select with userNumber=0x5A -> targetNumber=0x5A, score=1, back in REQUEST, gen_req=1.
REQ-039 Three wrong Selects (START_LIVES=3) -> lives 3->2->1->0, OVER, highScore updated to the current score.
REQ-040 ROUND_TICKS=4, no input -> after exactly 4 CEN ticks lives decrements and the state goes to REQUEST; non-CEN cycles do not decrement.
REQ-041 Same cycle CEN&Quit&Select(correct) in ROUND -> OVER, score unchanged; Quit+gen_ack in REQUEST -> OVER, targetNumber unchanged.
REQ-042 Score at 99, correct Select -> score stays 99; later Reset mid-ROUND -> all outputs 0, q_Idle=1 the next cycle.

Source files
------------

// File: rtl/binary_game_pkg.sv
// binary_game_pkg: shared widths, score default and one-hot state encoding for the binary game
package binary_game_pkg;
  localparam int NUM_W = 8;
  localparam int SCORE_W = 7;
  localparam int LIVES_W = 2;
  localparam int SCORE_MAX_DEF = 99;
  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_REQUEST = 4'b0010;
  localparam logic [3:0] S_ROUND = 4'b0100;
  localparam logic [3:0] S_OVER = 4'b1000;
endpackage

// File: rtl/round_timer.sv
// round_timer: per-round tick counter, loaded on a new target and decremented on enabled CEN ticks
module round_timer
  import binary_game_pkg::*;
#(
  parameter int TICKS = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic             cen,
  input  logic             run,
  output logic [NUM_W-1:0] time_left,
  output logic             expire
);
  assign expire = time_left == NUM_W'(1);
  always_ff @(posedge Clk)
    if (Reset) time_left <= '0;
    else if (load) time_left <= NUM_W'(TICKS);
    else if (cen && run && time_left != '0) time_left <= time_left - NUM_W'(1);
endmodule

// File: rtl/binary_round_ctrl.sv
// binary_round_ctrl: game FSM that fetches a random target, times each round and tracks score, lives and high score
module binary_round_ctrl
  import binary_game_pkg::*;
#(
  parameter int ROUND_TICKS = 10,
  parameter int START_LIVES = 3,
  parameter int SCORE_MAX = SCORE_MAX_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               CEN,
  input  logic               Start,
  input  logic               Select,
  input  logic               Quit,
  input  logic [NUM_W-1:0]   userNumber,
  output logic               gen_req,
  input  logic               gen_ack,
  input  logic [NUM_W-1:0]   gen_value,
  output logic [NUM_W-1:0]   targetNumber,
  output logic [NUM_W-1:0]   timeLeft,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] highScore,
  output logic [LIVES_W-1:0] lives,
  output logic               q_Idle,
  output logic               q_Request,
  output logic               q_Round,
  output logic               q_Over
);
  logic [3:0] state;
  logic [LIVES_W-1:0] lives_dec;
  logic [SCORE_W-1:0] score_inc;
  logic in_round, load, miss, expire;
  assign q_Idle = state == S_IDLE;
  assign q_Request = state == S_REQUEST;
  assign q_Round = state == S_ROUND;
  assign q_Over = state == S_OVER;
  assign gen_req = q_Request;
  assign in_round = q_Round;
  assign load = q_Request && gen_ack && !(CEN && Quit);
  assign lives_dec = lives - LIVES_W'(1);
  assign score_inc = score >= SCORE_W'(SCORE_MAX) ? score : score + SCORE_W'(1);
  // a wrong answer and a timer expiry are the same event: lose a life
  assign miss = in_round && CEN && !Quit && (Select ? userNumber != targetNumber : expire);
  round_timer #(.TICKS(ROUND_TICKS)) u_timer (
    .Clk(Clk),
    .Reset(Reset),
    .load(load),
    .cen(CEN),
    .run(in_round && !Quit && !Select),
    .time_left(timeLeft),
    .expire(expire)
  );
  always_ff @(posedge Clk)
    if (Reset) begin
      state <= S_IDLE;
      targetNumber <= '0;
      score <= '0;
      highScore <= '0;
      lives <= '0;
    end else if (miss) begin
      lives <= lives_dec;
      state <= lives_dec == '0 ? S_OVER : S_REQUEST;
      if (lives_dec == '0 && score > highScore) highScore <= score;
    end else
      case (state)
        S_IDLE:
          if (CEN && Start) begin
            state <= S_REQUEST;
            score <= '0;
            lives <= LIVES_W'(START_LIVES);
          end
        S_REQUEST:
          if (CEN && Quit) begin
            state <= S_OVER;
            if (score > highScore) highScore <= score;
          end else if (gen_ack) begin
            state <= S_ROUND;
            targetNumber <= gen_value;
          end
        S_ROUND:
          if (CEN && Quit) begin
            state <= S_OVER;
            if (score > highScore) highScore <= score;
          end else if (CEN && Select) begin
            score <= score_inc;
            state <= S_REQUEST;
          end
        S_OVER:
          if (CEN && Start) begin
            state <= S_REQUEST;
            score <= '0;
            lives <= LIVES_W'(START_LIVES);
          end else if (CEN && Select) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_binary_round_ctrl.sv
// tb_binary_round_ctrl: table-driven cycle-by-cycle check of binary_round_ctrl plus saturation and reset sequences
module tb_binary_round_ctrl;
  typedef struct packed {
    logic cen, start, sel, quit, ack;
    logic [7:0] gv, un;
  } in_t;
  typedef struct packed {
    logic [3:0] q;
    logic req;
    logic [7:0] tgt, tl;
    logic [6:0] sc, hs;
    logic [1:0] lv;
  } out_t;
  typedef struct packed {
    in_t i;
    out_t o;
  } vec_t;

  logic Clk = 0, Reset = 1, CEN = 0, Start = 0, Select = 0, Quit = 0, gen_ack = 0;
  logic [7:0] userNumber = 0, gen_value = 0;
  logic gen_req, q_Idle, q_Request, q_Round, q_Over;
  logic [7:0] targetNumber, timeLeft;
  logic [6:0] score, highScore;
  logic [1:0] lives;
  int errors = 0, checks = 0;
  vec_t vecs[$];

  binary_round_ctrl #(.ROUND_TICKS(4), .START_LIVES(3), .SCORE_MAX(99)) dut (
    .Clk(Clk), .Reset(Reset), .CEN(CEN), .Start(Start), .Select(Select), .Quit(Quit),
    .userNumber(userNumber), .gen_req(gen_req), .gen_ack(gen_ack), .gen_value(gen_value),
    .targetNumber(targetNumber), .timeLeft(timeLeft), .score(score), .highScore(highScore),
    .lives(lives), .q_Idle(q_Idle), .q_Request(q_Request), .q_Round(q_Round), .q_Over(q_Over)
  );

  always #5 Clk = ~Clk;

  function automatic in_t mi(input logic [4:0] f, input logic [7:0] gv, input logic [7:0] un);
    mi = {f, gv, un};
  endfunction

  function automatic out_t mo(input logic [3:0] q, input logic r, input logic [7:0] t,
                              input logic [7:0] tl, input logic [6:0] sc, input logic [6:0] hs,
                              input logic [1:0] lv);
    mo = {q, r, t, tl, sc, hs, lv};
  endfunction

  task automatic add(input in_t i, input out_t o);
    vecs.push_back({i, o});
  endtask

  task automatic apply(input in_t v);
    @(negedge Clk);
    {CEN, Start, Select, Quit, gen_ack, gen_value, userNumber} = v;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t got;
    got = {q_Idle, q_Request, q_Round, q_Over, gen_req, targetNumber, timeLeft, score, highScore, lives};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got q=%b req=%b tgt=%h tl=%0d sc=%0d hs=%0d lv=%0d, want q=%b req=%b tgt=%h tl=%0d sc=%0d hs=%0d lv=%0d",
               name, got.q, got.req, got.tgt, got.tl, got.sc, got.hs, got.lv,
               exp.q, exp.req, exp.tgt, exp.tl, exp.sc, exp.hs, exp.lv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // flags order {cen,start,sel,quit,ack}; q order {Idle,Request,Round,Over}
    add(mi(5'b10000, 8'h00, 8'h00), mo(4'b1000, 0, 8'h00, 8'd0, 7'd0, 7'd0, 2'd0));
    add(mi(5'b01000, 8'h00, 8'h00), mo(4'b1000, 0, 8'h00, 8'd0, 7'd0, 7'd0, 2'd0));
    add(mi(5'b11000, 8'h00, 8'h00), mo(4'b0100, 1, 8'h00, 8'd0, 7'd0, 7'd0, 2'd3));
    add(mi(5'b00001, 8'h5A, 8'h00), mo(4'b0010, 0, 8'h5A, 8'd4, 7'd0, 7'd0, 2'd3));
    add(mi(5'b10100, 8'h00, 8'h5A), mo(4'b0100, 1, 8'h5A, 8'd4, 7'd1, 7'd0, 2'd3));
    add(mi(5'b00001, 8'h33, 8'h00), mo(4'b0010, 0, 8'h33, 8'd4, 7'd1, 7'd0, 2'd3));
    add(mi(5'b10000, 8'h00, 8'h00), mo(4'b0010, 0, 8'h33, 8'd3, 7'd1, 7'd0, 2'd3));
    add(mi(5'b00000, 8'h00, 8'h00), mo(4'b0010, 0, 8'h33, 8'd3, 7'd1, 7'd0, 2'd3));
    add(mi(5'b10000, 8'h00, 8'h00), mo(4'b0010, 0, 8'h33, 8'd2, 7'd1, 7'd0, 2'd3));
    add(mi(5'b10000, 8'h00, 8'h00), mo(4'b0010, 0, 8'h33, 8'd1, 7'd1, 7'd0, 2'd3));
    add(mi(5'b00000, 8'h00, 8'h00), mo(4'b0010, 0, 8'h33, 8'd1, 7'd1, 7'd0, 2'd3));
    add(mi(5'b10000, 8'h00, 8'h00), mo(4'b0100, 1, 8'h33, 8'd0, 7'd1, 7'd0, 2'd2));
    add(mi(5'b00001, 8'h11, 8'h00), mo(4'b0010, 0, 8'h11, 8'd4, 7'd1, 7'd0, 2'd2));
    add(mi(5'b10100, 8'h00, 8'h12), mo(4'b0100, 1, 8'h11, 8'd4, 7'd1, 7'd0, 2'd1));
    add(mi(5'b00001, 8'h22, 8'h00), mo(4'b0010, 0, 8'h22, 8'd4, 7'd1, 7'd0, 2'd1));
    add(mi(5'b10100, 8'h00, 8'h00), mo(4'b0001, 0, 8'h22, 8'd4, 7'd1, 7'd1, 2'd0));
    add(mi(5'b00001, 8'h99, 8'h00), mo(4'b0001, 0, 8'h22, 8'd4, 7'd1, 7'd1, 2'd0));
    add(mi(5'b10100, 8'h00, 8'h00), mo(4'b1000, 0, 8'h22, 8'd4, 7'd1, 7'd1, 2'd0));
    add(mi(5'b11000, 8'h00, 8'h00), mo(4'b0100, 1, 8'h22, 8'd4, 7'd0, 7'd1, 2'd3));
    add(mi(5'b00001, 8'h01, 8'h00), mo(4'b0010, 0, 8'h01, 8'd4, 7'd0, 7'd1, 2'd3));
    add(mi(5'b10100, 8'h00, 8'h01), mo(4'b0100, 1, 8'h01, 8'd4, 7'd1, 7'd1, 2'd3));
    add(mi(5'b00001, 8'h02, 8'h00), mo(4'b0010, 0, 8'h02, 8'd4, 7'd1, 7'd1, 2'd3));
    add(mi(5'b10100, 8'h00, 8'h02), mo(4'b0100, 1, 8'h02, 8'd4, 7'd2, 7'd1, 2'd3));
    add(mi(5'b00001, 8'h03, 8'h00), mo(4'b0010, 0, 8'h03, 8'd4, 7'd2, 7'd1, 2'd3));
    add(mi(5'b10100, 8'h00, 8'h00), mo(4'b0100, 1, 8'h03, 8'd4, 7'd2, 7'd1, 2'd2));
    add(mi(5'b00001, 8'h04, 8'h00), mo(4'b0010, 0, 8'h04, 8'd4, 7'd2, 7'd1, 2'd2));
    add(mi(5'b10100, 8'h00, 8'h05), mo(4'b0100, 1, 8'h04, 8'd4, 7'd2, 7'd1, 2'd1));
    add(mi(5'b00001, 8'h06, 8'h00), mo(4'b0010, 0, 8'h06, 8'd4, 7'd2, 7'd1, 2'd1));
    add(mi(5'b10100, 8'h00, 8'h07), mo(4'b0001, 0, 8'h06, 8'd4, 7'd2, 7'd2, 2'd0));
    add(mi(5'b10000, 8'h00, 8'h00), mo(4'b0001, 0, 8'h06, 8'd4, 7'd2, 7'd2, 2'd0));
    add(mi(5'b11000, 8'h00, 8'h00), mo(4'b0100, 1, 8'h06, 8'd4, 7'd0, 7'd2, 2'd3));
    add(mi(5'b00001, 8'h0A, 8'h00), mo(4'b0010, 0, 8'h0A, 8'd4, 7'd0, 7'd2, 2'd3));
    add(mi(5'b10100, 8'h00, 8'h0A), mo(4'b0100, 1, 8'h0A, 8'd4, 7'd1, 7'd2, 2'd3));
    add(mi(5'b00001, 8'h0B, 8'h00), mo(4'b0010, 0, 8'h0B, 8'd4, 7'd1, 7'd2, 2'd3));
    add(mi(5'b10110, 8'h00, 8'h0B), mo(4'b0001, 0, 8'h0B, 8'd4, 7'd1, 7'd2, 2'd3));
    add(mi(5'b11000, 8'h00, 8'h00), mo(4'b0100, 1, 8'h0B, 8'd4, 7'd0, 7'd2, 2'd3));
    add(mi(5'b10011, 8'hCC, 8'h00), mo(4'b0001, 0, 8'h0B, 8'd4, 7'd0, 7'd2, 2'd3));
    add(mi(5'b11000, 8'h00, 8'h00), mo(4'b0100, 1, 8'h0B, 8'd4, 7'd0, 7'd2, 2'd3));

    apply(mi(5'b00000, 8'h00, 8'h00));
    apply(mi(5'b11100, 8'h00, 8'h00));
    check("reset", mo(4'b1000, 0, 8'h00, 8'd0, 7'd0, 7'd0, 2'd0));
    Reset = 0;
    foreach (vecs[n]) begin
      apply(vecs[n].i);
      check($sformatf("vec%0d", n), vecs[n].o);
    end

    for (int k = 1; k <= 100; k++) begin
      apply(mi(5'b00001, 8'(k), 8'h00));
      apply(mi(5'b10100, 8'h00, 8'(k)));
      check($sformatf("sat%0d", k), mo(4'b0100, 1, 8'(k), 8'd4, k > 99 ? 7'd99 : 7'(k), 7'd2, 2'd3));
    end
    apply(mi(5'b00001, 8'h77, 8'h00));
    apply(mi(5'b10010, 8'h00, 8'h00));
    check("quit_hs99", mo(4'b0001, 0, 8'h77, 8'd4, 7'd99, 7'd99, 2'd3));
    apply(mi(5'b11000, 8'h00, 8'h00));
    apply(mi(5'b00001, 8'h55, 8'h00));
    check("round55", mo(4'b0010, 0, 8'h55, 8'd4, 7'd0, 7'd99, 2'd3));
    Reset = 1;
    apply(mi(5'b10100, 8'h00, 8'h55));
    check("reset_mid_round", mo(4'b1000, 0, 8'h00, 8'd0, 7'd0, 7'd0, 2'd0));
    Reset = 0;
    apply(mi(5'b10000, 8'h00, 8'h00));
    check("post_reset_idle", mo(4'b1000, 0, 8'h00, 8'd0, 7'd0, 7'd0, 2'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
